// File: rtl/riscv_trace_buffer_pkg.sv
// Shared definitions for the retire-trace collector: class codes and opcode decode.
// Optional build macro: TRACE_BRANCH_ONLY_EN (see riscv_trace_buffer.sv).
package riscv_trace_buffer_pkg;

  localparam logic [2:0] TRACE_CLASS_ALU     = 3'd0;
  localparam logic [2:0] TRACE_CLASS_BRANCH  = 3'd1;
  localparam logic [2:0] TRACE_CLASS_JAL     = 3'd2;
  localparam logic [2:0] TRACE_CLASS_JALR    = 3'd3;
  localparam logic [2:0] TRACE_CLASS_LOAD    = 3'd4;
  localparam logic [2:0] TRACE_CLASS_STORE   = 3'd5;
  localparam logic [2:0] TRACE_CLASS_SYSTEM  = 3'd6;
  localparam logic [2:0] TRACE_CLASS_UNKNOWN = 3'd7;

  function automatic logic [2:0] trace_class(input logic [31:0] op);
    logic [2:0] k;
    k = TRACE_CLASS_UNKNOWN;
    unique case (op[6:0])
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111: k = TRACE_CLASS_ALU;
      7'b1100011: k = TRACE_CLASS_BRANCH;
      7'b1101111: k = TRACE_CLASS_JAL;
      7'b1100111: k = TRACE_CLASS_JALR;
      7'b0000011: k = TRACE_CLASS_LOAD;
      7'b0100011: k = TRACE_CLASS_STORE;
      7'b1110011,
      7'b0001111: k = TRACE_CLASS_SYSTEM;
      default:    k = TRACE_CLASS_UNKNOWN;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Single-clock per-core trace FIFO with synchronous flush.
// Read data is the head entry, valid whenever not empty.
module riscv_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/riscv_trace_buffer.sv
// Multi-core retire-trace collector: per-core FIFOs drained round-robin.
// TRACE_BRANCH_ONLY_EN: capture only branch/jal/jalr/system retirements.
module riscv_trace_buffer
  import riscv_trace_buffer_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 8,
  parameter int TS_W      = 16,
  parameter int SEQ_W     = 16,
  parameter int DROP_W    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        flush_i,
  input  logic [NUM_CORES-1:0]        valid_i,
  input  logic [32*NUM_CORES-1:0]     pc_i,
  input  logic [32*NUM_CORES-1:0]     opcode_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [2:0]                  out_core_o,
  output logic [SEQ_W-1:0]            out_seq_o,
  output logic [TS_W-1:0]             out_ts_o,
  output logic [31:0]                 out_pc_o,
  output logic [31:0]                 out_opcode_o,
  output logic [2:0]                  out_class_o,
  output logic                        out_lost_o,
  output logic [DROP_W*NUM_CORES-1:0] drop_cnt_o
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [TS_W-1:0]  ts;
    logic [31:0]      pc;
    logic [31:0]      op;
    logic [2:0]       cls;
    logic             lost;
  } rec_t;

  rec_t                 wr_rec [NUM_CORES];
  rec_t                 rd_rec [NUM_CORES];
  rec_t                 o_rec;
  logic [2:0]           cls    [NUM_CORES];
  logic [SEQ_W-1:0]     seq_q  [NUM_CORES];
  logic [DROP_W-1:0]    drop_q [NUM_CORES];
  logic [NUM_CORES-1:0] keep, want, full, empty;
  logic [NUM_CORES-1:0] push, pop, drop, lost_q;
  logic [TS_W-1:0]      ts_q;
  logic [CW-1:0]        rr_q, win;
  logic [2:0]           core_q;
  logic                 found, load, valid_q;

  assign load = !valid_q || out_ready_i;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign cls[c] = trace_class(opcode_i[32*c +: 32]);
`ifdef TRACE_BRANCH_ONLY_EN
    assign keep[c] = (cls[c] == TRACE_CLASS_BRANCH) ||
                     (cls[c] == TRACE_CLASS_JAL) ||
                     (cls[c] == TRACE_CLASS_JALR) ||
                     (cls[c] == TRACE_CLASS_SYSTEM);
`else
    assign keep[c] = 1'b1;
`endif
    assign want[c] = enable_i && valid_i[c] && !flush_i && keep[c];
    assign pop[c]  = load && found && (win == CW'(c));
    // A full FIFO still accepts when its head leaves this same cycle
    assign push[c] = want[c] && (!full[c] || pop[c]);
    assign drop[c] = want[c] && full[c] && !pop[c];
    assign wr_rec[c] = {seq_q[c], ts_q, pc_i[32*c +: 32],
                        opcode_i[32*c +: 32], cls[c], lost_q[c]};
    assign drop_cnt_o[DROP_W*c +: DROP_W] = drop_q[c];

    riscv_trace_fifo #(
      .W     ($bits(rec_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .wdata_i (wr_rec[c]),
      .rdata_o (rd_rec[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  always_comb begin
    logic [CW:0] idx;
    found = 1'b0;
    win   = rr_q;
    idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, rr_q} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CORES)) idx = idx - (CW+1)'(NUM_CORES);
      if (!found && !empty[idx[CW-1:0]]) begin
        found = 1'b1;
        win   = idx[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ts_q   <= '0;
      lost_q <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        seq_q[c]  <= '0;
        drop_q[c] <= '0;
      end
    end else begin
      ts_q <= ts_q + TS_W'(1);
      for (int c = 0; c < NUM_CORES; c++) begin
        if (enable_i && valid_i[c]) seq_q[c] <= seq_q[c] + SEQ_W'(1);
        if (flush_i) begin
          drop_q[c] <= '0;
          lost_q[c] <= 1'b0;
        end else if (drop[c]) begin
          if (drop_q[c] != '1) drop_q[c] <= drop_q[c] + DROP_W'(1);
          lost_q[c] <= 1'b1;
        end else if (push[c]) begin
          lost_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      core_q  <= '0;
      o_rec   <= '0;
      rr_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      core_q  <= '0;
      o_rec   <= '0;
    end else if (load) begin
      valid_q <= found;
      if (found) begin
        o_rec  <= rd_rec[win];
        core_q <= 3'(win);
        rr_q   <= (win == CW'(NUM_CORES-1)) ? '0 : win + CW'(1);
      end
    end
  end

  assign out_valid_o  = valid_q;
  assign out_core_o   = core_q;
  assign out_seq_o    = o_rec.seq;
  assign out_ts_o     = o_rec.ts;
  assign out_pc_o     = o_rec.pc;
  assign out_opcode_o = o_rec.op;
  assign out_class_o  = o_rec.cls;
  assign out_lost_o   = o_rec.lost;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_riscv_trace_buffer;

  localparam int NC    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          fl  = 1'b0;
  logic          rdy = 1'b0;
  logic [NC-1:0] vld = '0;
  logic [63:0]   pc  = '0;
  logic [63:0]   op  = '0;

  logic        out_valid, out_lost;
  logic [2:0]  out_core, out_class;
  logic [15:0] out_seq, out_ts;
  logic [31:0] out_pc, out_opcode;
  logic [15:0] drop_cnt;

  riscv_trace_buffer #(
    .NUM_CORES (NC),
    .DEPTH     (DEPTH),
    .TS_W      (16),
    .SEQ_W     (16),
    .DROP_W    (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (en),
    .flush_i      (fl),
    .valid_i      (vld),
    .pc_i         (pc),
    .opcode_i     (op),
    .out_valid_o  (out_valid),
    .out_ready_i  (rdy),
    .out_core_o   (out_core),
    .out_seq_o    (out_seq),
    .out_ts_o     (out_ts),
    .out_pc_o     (out_pc),
    .out_opcode_o (out_opcode),
    .out_class_o  (out_class),
    .out_lost_o   (out_lost),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  core;
    logic [15:0] seq;
    logic [15:0] ts;
    logic [31:0] pc;
    logic [31:0] op;
    logic [2:0]  cls;
    logic        lost;
  } mrec_t;

  mrec_t       mq [NC][$];
  mrec_t       mo;
  bit          mov;
  int          mrr;
  logic [15:0] mseq [NC];
  logic [15:0] mts;
  int          mdrop [NC];
  bit          mlost [NC];

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [31:0] ops [11] = '{
    32'h00500093, 32'h02b50533, 32'h000012b7, 32'h00000063,
    32'h0080006f, 32'h00008067, 32'h0000a283, 32'h0050a023,
    32'h34029073, 32'h0000100f, 32'h0000000b
  };

  function automatic logic [2:0] mclass(input logic [31:0] o);
    case (o[6:0])
      7'h33, 7'h13, 7'h37, 7'h17: return 3'd0;
      7'h63: return 3'd1;
      7'h6f: return 3'd2;
      7'h67: return 3'd3;
      7'h03: return 3'd4;
      7'h23: return 3'd5;
      7'h73, 7'h0f: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit    load;
    int    w;
    mrec_t r;
    logic [2:0] k;
    bit    keep;
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        mseq[c]  = '0;
        mdrop[c] = 0;
        mlost[c] = 0;
      end
      mov = 0; mo = '0; mrr = 0; mts = '0;
      return;
    end
    load = !mov || rdy;
    w = -1;
    for (int i = 0; i < NC; i++) begin
      int idx;
      idx = (mrr + i) % NC;
      if (w < 0 && mq[idx].size() > 0) w = idx;
    end
    if (fl) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        mdrop[c] = 0;
        mlost[c] = 0;
      end
      mov = 0; mo = '0;
    end else begin
      if (load) begin
        if (w >= 0) begin
          mo  = mq[w].pop_front();
          mov = 1;
          mrr = (w + 1) % NC;
        end else begin
          mov = 0;
        end
      end
      for (int c = 0; c < NC; c++) begin
        k = mclass(op[32*c +: 32]);
`ifdef TRACE_BRANCH_ONLY_EN
        keep = (k == 3'd1) || (k == 3'd2) || (k == 3'd3) || (k == 3'd6);
`else
        keep = 1'b1;
`endif
        if (en && vld[c] && keep) begin
          if (mq[c].size() < DEPTH) begin
            r = '{core: 3'(c), seq: mseq[c], ts: mts,
                  pc: pc[32*c +: 32], op: op[32*c +: 32],
                  cls: k, lost: mlost[c]};
            mq[c].push_back(r);
            mlost[c] = 0;
          end else begin
            if (mdrop[c] < 255) mdrop[c]++;
            mlost[c] = 1;
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) if (en && vld[c]) mseq[c]++;
    mts++;
  endtask

  task automatic compare_all();
    chk("valid", out_valid, mov);
    if (mov) begin
      chk("core", out_core, mo.core);
      chk("seq", out_seq, mo.seq);
      chk("ts", out_ts, mo.ts);
      chk("pc", out_pc, mo.pc);
      chk("opcode", out_opcode, mo.op);
      chk("class", out_class, mo.cls);
      chk("lost", out_lost, mo.lost);
    end
    for (int c = 0; c < NC; c++)
      chk($sformatf("drop%0d", c), drop_cnt[8*c +: 8], mdrop[c]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b1; en = 1'b1; rdy = 1'b1;

    // 1: addi on core0 and beq on core1 in the same cycle
    pc  = {32'h200, 32'h100};
    op  = {32'h00000063, 32'h00500093};
    vld = 2'b11;
    step();
    vld = 2'b00;
    chk("t1_lat0", out_valid, 0);
    step();
`ifndef TRACE_BRANCH_ONLY_EN
    chk("t1_valid", out_valid, 1);
    chk("t1_core0", out_core, 0);
    chk("t1_cls0", out_class, 0);
    chk("t1_seq0", out_seq, 0);
    step();
    chk("t1_core1", out_core, 1);
    chk("t1_cls1", out_class, 1);
    chk("t1_seq1", out_seq, 0);
`endif
    repeat (4) step();

    // 2: stall sink, overflow core0 FIFO by one
    op  = {32'h0080006f, 32'h0080006f};
    rdy = 1'b0;
    vld = 2'b01;
    for (int i = 0; i < 10; i++) begin pc[31:0] = 32'h1000 + 4 * i; step(); end
    chk("t2_drop", drop_cnt[7:0], 1);
    vld = 2'b10;
    repeat (300) step();
    chk("t2_sat", drop_cnt[15:8], 255);
    vld = 2'b00; rdy = 1'b1;
    repeat (30) step();
    vld = 2'b01; pc[31:0] = 32'h2000;
    step();
    vld = 2'b00;
    step();
    chk("t2_lost", out_lost, 1);
    chk("t2_lcore", out_core, 0);

    // 3: both cores streaming
    vld = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      pc = {$urandom, $urandom};
      step();
      if (k >= 2) begin
        chk("t3_valid", out_valid, 1);
        chk("t3_alt", out_core, (k % 2 == 0) ? 1 : 0);
      end
    end

    // 5: flush mid-stream
    fl = 1'b1;
    step();
    fl = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_drop", drop_cnt, 0);
    repeat (6) step();
    vld = 2'b00;
    repeat (20) step();

    // 4: full FIFO popped and pushed in the same cycle
    rdy = 1'b0; vld = 2'b01;
    repeat (9) step();
    rdy = 1'b1;
    step();
    chk("t4_drop", drop_cnt[7:0], 0);
    vld = 2'b00;
    repeat (20) step();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      en  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      vld = 2'($urandom);
      pc  = {$urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc};
      op  = {ops[$urandom_range(0, 10)], ops[$urandom_range(0, 10)]};
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
